// File: rtl/shift_issue_stage.sv
// Decode-to-execute issue stage for the 16-bit barrel shifter: two-entry skid buffer with flush.
// Optional stall counter output enabled by defining SHIFT_ISSUE_PERF_EN.
module shift_issue_stage #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_opnd,
    input  logic [15:0]      in_cnt_reg,
    input  logic [3:0]       in_cnt_imm,
    input  logic             in_cnt_sel,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_opnd,
    output logic [3:0]       out_cnt,
    output logic [1:0]       out_op,
    output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_ISSUE_PERF_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0]      opnd;
        logic [3:0]       cnt;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    logic   in_ready_q, in_ready_d;

    logic   accept;
    logic   drain;
    entry_t new_entry;
    logic   cnt_reg_unused;

    // Only the low nibble of the register count reaches the shifter.
    assign cnt_reg_unused = ^in_cnt_reg[15:4];

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        new_entry      = '0;
        new_entry.opnd = in_opnd;
        new_entry.cnt  = in_cnt_sel ? in_cnt_imm : in_cnt_reg[3:0];
        new_entry.op   = in_op;
        new_entry.tag  = in_tag;
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_d     = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    s_d     = new_entry;
                    state_d = FULL;
                end else if (accept && drain) begin
                    m_d = new_entry;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    m_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A drain in the flush cycle has already been consumed; everything else is dropped.
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Outputs are forced to zero whenever nothing is presented.
    always_comb begin
        out_opnd = '0;
        out_cnt  = '0;
        out_op   = '0;
        out_tag  = '0;
        if (out_valid) begin
            out_opnd = m_q.opnd;
            out_cnt  = m_q.cnt;
            out_op   = m_q.op;
            out_tag  = m_q.tag;
        end
    end

`ifdef SHIFT_ISSUE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]  stall_inc;
    logic [16:0] stall_sum;

    always_comb begin
        stall_inc   = {1'b0, in_valid & ~in_ready_q} + {1'b0, out_valid & ~out_ready};
        stall_sum   = {1'b0, stall_cnt_q} + {15'b0, stall_inc};
        stall_cnt_d = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
